// File: rtl/i2s_pkg.sv
// Shared definitions for the i2s_rx_master capture path: frame geometry,
// slot data offset and the receive FSM state type.
package i2s_pkg;

  localparam int FRAME_BITS  = 64;  // BCLK cycles per stereo frame
  localparam int SLOT_BITS   = 32;  // BCLK cycles per channel slot
  localparam int SLOT_OFFSET = 1;   // I2S one-bit delay after the LRCLK edge

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_e;

endpackage

// File: rtl/i2s_clkgen.sv
// BCLK/LRCLK generator: a 0..BCLK_HALF-1 divider toggles BCLK at terminal
// count, a 6-bit bit counter advances on every BCLK falling edge, and LRCLK
// mirrors bit 5 of that counter so it changes together with BCLK falling.
// rise_o/fall_o are one-cycle strobes high in the cycle whose clock edge
// makes BCLK go 0->1 / 1->0.
module i2s_clkgen #(
  parameter int BCLK_HALF = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       bclk_o,
  output logic       lrclk_o,
  output logic [5:0] bit_cnt_o,
  output logic       rise_o,
  output logic       fall_o
);

  localparam int DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  logic [DW-1:0] div_q, div_d;
  logic          bclk_q, bclk_d;
  logic          lrclk_q, lrclk_d;
  logic [5:0]    bit_q, bit_d;
  logic          term_s;

  assign term_s = (div_q == DW'(BCLK_HALF - 1));
  assign rise_o = term_s & ~bclk_q;
  assign fall_o = term_s & bclk_q;

  // Next-state for divider, bit clock, bit counter and word select.
  always_comb begin
    div_d   = term_s ? '0 : div_q + DW'(1);
    bclk_d  = term_s ? ~bclk_q : bclk_q;
    bit_d   = fall_o ? bit_q + 6'd1 : bit_q;
    lrclk_d = bit_d[5];
  end

  // Clock-generation state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
      bit_q   <= 6'd0;
    end else begin
      div_q   <= div_d;
      bclk_q  <= bclk_d;
      lrclk_q <= lrclk_d;
      bit_q   <= bit_d;
    end
  end

  assign bclk_o    = bclk_q;
  assign lrclk_o   = lrclk_q;
  assign bit_cnt_o = bit_q;

endmodule

// File: rtl/i2s_rx_master.sv
// I2S master receiver: drives BCLK/LRCLK, deserialises a stereo frame and
// presents each left/right pair on a valid/ready interface with a sticky
// overrun flag for pairs dropped under backpressure.
// Build option I2S_RX_TESTPAT_EN: replace captured data with a frame counter
// (left) and its complement (right); i2s_sd is then ignored.
module i2s_rx_master
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 24,
  parameter int BCLK_HALF    = 4,
  parameter int SLOT_BITS    = 32
) (
  input  logic                    clk_25m,
  input  logic                    rst,
  output logic                    i2s_bclk,
  output logic                    i2s_lrclk,
  input  logic                    i2s_sd,
  output logic [SAMPLE_WIDTH-1:0] sample_left,
  output logic [SAMPLE_WIDTH-1:0] sample_right,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic                    overrun,
  input  logic                    overrun_clr
);

  logic [5:0]              bit_cnt_s;
  logic                    rise_s, fall_s;
  state_e                  state_q, state_d;
  logic                    commit_s, load_ok_s;
  logic [SAMPLE_WIDTH-1:0] new_l_s, new_r_s;
  logic [SAMPLE_WIDTH-1:0] left_q, left_d, right_q, right_d;
  logic                    valid_q, valid_d, ovr_q, ovr_d;

  i2s_clkgen #(.BCLK_HALF(BCLK_HALF)) u_clkgen (
    .clk       (clk_25m),
    .rst       (rst),
    .bclk_o    (i2s_bclk),
    .lrclk_o   (i2s_lrclk),
    .bit_cnt_o (bit_cnt_s),
    .rise_o    (rise_s),
    .fall_o    (fall_s)
  );

  // The pair is complete once the counter has wrapped back to 0 in RIGHT.
  assign commit_s = (state_q == ST_RIGHT) && (bit_cnt_s == 6'd0);

  // Slot tracking FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SYNC:  if (bit_cnt_s == 6'd0) state_d = ST_LEFT;
      ST_LEFT:  if (bit_cnt_s == 6'(SLOT_BITS)) state_d = ST_RIGHT;
      ST_RIGHT: if (bit_cnt_s == 6'd0) state_d = ST_LEFT;
      default:  state_d = ST_SYNC;
    endcase
  end

`ifdef I2S_RX_TESTPAT_EN
  logic [SAMPLE_WIDTH-1:0] frame_q, frame_d;

  assign new_l_s = frame_q;
  assign new_r_s = ~frame_q;

  // Frame counter advances once per completed frame.
  always_comb begin
    frame_d = commit_s ? frame_q + SAMPLE_WIDTH'(1) : frame_q;
  end

  // Frame counter register.
  always_ff @(posedge clk_25m) begin
    if (rst) frame_q <= '0;
    else     frame_q <= frame_d;
  end
`else
  logic [SAMPLE_WIDTH-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
  logic                    in_left_s, in_right_s;

  assign in_left_s  = (int'(bit_cnt_s) >= SLOT_OFFSET) &&
                      (int'(bit_cnt_s) <  SLOT_OFFSET + SAMPLE_WIDTH);
  assign in_right_s = (int'(bit_cnt_s) >= SLOT_BITS + SLOT_OFFSET) &&
                      (int'(bit_cnt_s) <  SLOT_BITS + SLOT_OFFSET + SAMPLE_WIDTH);
  assign new_l_s = sh_l_q;
  assign new_r_s = sh_r_q;

  // MSB-first shift-in of the data bits on each BCLK rising edge.
  always_comb begin
    sh_l_d = sh_l_q;
    sh_r_d = sh_r_q;
    if (rise_s && (state_q != ST_SYNC)) begin
      if (in_left_s)  sh_l_d = (sh_l_q << 1) | SAMPLE_WIDTH'(i2s_sd);
      else            sh_l_d = sh_l_q;
      if (in_right_s) sh_r_d = (sh_r_q << 1) | SAMPLE_WIDTH'(i2s_sd);
      else            sh_r_d = sh_r_q;
    end else begin
      sh_l_d = sh_l_q;
      sh_r_d = sh_r_q;
    end
  end

  // Shift registers.
  always_ff @(posedge clk_25m) begin
    if (rst) begin
      sh_l_q <= '0;
      sh_r_q <= '0;
    end else begin
      sh_l_q <= sh_l_d;
      sh_r_q <= sh_r_d;
    end
  end
`endif

  assign load_ok_s = ~valid_q | sample_ready;

  // Output handshake: load on commit when the slot is free or being emptied,
  // otherwise drop the new pair and flag overrun (set beats clear).
  always_comb begin
    left_d  = left_q;
    right_d = right_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (commit_s && load_ok_s) begin
      left_d  = new_l_s;
      right_d = new_r_s;
      valid_d = 1'b1;
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (commit_s && !load_ok_s) ovr_d = 1'b1;
    else if (overrun_clr)       ovr_d = 1'b0;
    else                        ovr_d = ovr_q;
  end

  // FSM and output registers.
  always_ff @(posedge clk_25m) begin
    if (rst) begin
      state_q <= ST_SYNC;
      left_q  <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      right_q <= right_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sample_left  = left_q;
  assign sample_right = right_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_i2s_rx_master.sv
// Self-checking bench for i2s_rx_master. A behavioural I2S device counts BCLK
// falling edges to know its bit position, serialises one random (or fixed)
// stereo pair per frame and records each completed pair in a queue of
// expected outputs.
module tb_i2s_rx_master;

  localparam int SW   = 24;
  localparam int HALF = 4;

  typedef struct {
    logic [SW-1:0] l;
    logic [SW-1:0] r;
  } pair_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sd = 1'b0;
  logic          ready = 1'b0;
  logic          clr = 1'b0;
  logic          bclk, lrclk, valid, ovr;
  logic [SW-1:0] sl, sr;

  int checks = 0;
  int failures = 0;

  pair_t         expq[$];
  logic [SW-1:0] cur_l, cur_r;
  logic [SW-1:0] fix_l = 24'h7FFFFF;
  logic [SW-1:0] fix_r = 24'h800001;
  bit            use_fixed = 1'b0;
  int            p = 0;
  int            idx = 0;
  logic          prev_bclk = 1'b0;

  pair_t e0, e1;
  int    n;
  bit    ok;
  int    cnt;
  logic  bc_prev, lr_prev;

  i2s_rx_master #(.SAMPLE_WIDTH(SW), .BCLK_HALF(HALF), .SLOT_BITS(32)) dut (
    .clk_25m      (clk),
    .rst          (rst),
    .i2s_bclk     (bclk),
    .i2s_lrclk    (lrclk),
    .i2s_sd       (sd),
    .sample_left  (sl),
    .sample_right (sr),
    .sample_valid (valid),
    .sample_ready (ready),
    .overrun      (ovr),
    .overrun_clr  (clr)
  );

  always #20 clk = ~clk;

  function automatic logic sd_for(int pos, logic [SW-1:0] l, logic [SW-1:0] r);
    if (pos >= 1 && pos <= SW)            return l[SW-pos];
    else if (pos >= 33 && pos <= 32 + SW) return r[SW-(pos-32)];
    else                                  return 1'($urandom_range(1, 0));
  endfunction

  task automatic pick();
`ifdef I2S_RX_TESTPAT_EN
    cur_l = SW'(idx);
    cur_r = ~SW'(idx);
`else
    cur_l = use_fixed ? fix_l : SW'($urandom);
    cur_r = use_fixed ? fix_r : SW'($urandom);
`endif
  endtask

  // Device model: runs at #1 after each clock edge, main sequence at #2.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        p = 0;
        idx = 0;
        prev_bclk = 1'b0;
        expq.delete();
        pick();
        sd = 1'($urandom_range(1, 0));
      end else begin
        if (prev_bclk && !bclk) begin
          p = (p + 1) % 64;
          if (p == 0) begin
            expq.push_back('{cur_l, cur_r});
            idx++;
            pick();
          end
`ifdef I2S_RX_TESTPAT_EN
          sd = 1'($urandom_range(1, 0));
`else
          sd = sd_for(p, cur_l, cur_r);
`endif
        end
        prev_bclk = bclk;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic pop_exp(output pair_t e);
    if (expq.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL exp_queue_empty observed=0 expected=1");
      e = '{'0, '0};
    end else begin
      e = expq.pop_front();
    end
  endtask

  task automatic do_reset(int cyc);
    rst = 1'b1;
    repeat (cyc) tick();
    rst = 1'b0;
  endtask

  task automatic wait_valid(int budget, output int cycles, output bit got);
    cycles = 0;
    while (!valid && cycles < budget) begin
      tick();
      cycles++;
    end
    got = valid;
  endtask

  initial begin
    int last_rise, nrise, bad_per, first_rise, align_bad, nlr_r, nlr_f;
    int lr_r[4];
    int lr_f[4];

    // ---- reset state and idle clock timing ----
    ready = 1'b1;
    repeat (5) tick();
    chk("rst_bclk",  32'(bclk),  32'd0);
    chk("rst_lrclk", 32'(lrclk), 32'd0);
    chk("rst_left",  32'(sl),    32'd0);
    chk("rst_right", 32'(sr),    32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_ovr",   32'(ovr),   32'd0);
    rst = 1'b0;
    last_rise = 0; nrise = 0; bad_per = 0; first_rise = -1; align_bad = 0;
    nlr_r = 0; nlr_f = 0;
    bc_prev = bclk; lr_prev = lrclk;
    for (int c = 1; c <= 2000; c++) begin
      tick();
      if (!bc_prev && bclk) begin
        if (nrise == 0) first_rise = c;
        else if (c - last_rise != 2 * HALF) bad_per++;
        last_rise = c;
        nrise++;
      end
      if (lrclk !== lr_prev) begin
        if (!(bc_prev && !bclk)) align_bad++;
        if (lrclk) begin if (nlr_r < 4) lr_r[nlr_r] = c; nlr_r++; end
        else       begin if (nlr_f < 4) lr_f[nlr_f] = c; nlr_f++; end
      end
      bc_prev = bclk;
      lr_prev = lrclk;
    end
    chk("bclk_first_rise", 32'(first_rise), 32'(HALF));
    chk("bclk_period_bad", 32'(bad_per), 32'd0);
    chk("bclk_rises", 32'(nrise), 32'd250);
    chk("lrclk_rises", 32'(nlr_r), 32'd4);
    chk("lrclk_first_rise", 32'(lr_r[0]), 32'd256);
    chk("lrclk_high", 32'(lr_f[0] - lr_r[0]), 32'd256);
    chk("lrclk_period", 32'(lr_r[1] - lr_r[0]), 32'd512);
    chk("lrclk_align_bad", 32'(align_bad), 32'd0);

    // ---- fixed values, ready=1: latency, data, one-cycle pulses ----
    use_fixed = 1'b1;
    do_reset(3);
    wait_valid(700, n, ok);
    chk("first_valid_latency", 32'(n), 32'd513);
    pop_exp(e0);
    chk("fixed_left",  32'(sl), 32'(e0.l));
    chk("fixed_right", 32'(sr), 32'(e0.r));
`ifndef I2S_RX_TESTPAT_EN
    chk("fixed_left_const",  32'(sl), 32'h007FFFFF);
    chk("fixed_right_const", 32'(sr), 32'h00800001);
`else
    chk("tp_first_left",  32'(sl), 32'h00000000);
    chk("tp_first_right", 32'(sr), 32'h00FFFFFF);
`endif
    tick();
    chk("valid_pulse_drop", 32'(valid), 32'd0);
    cnt = 0;
    for (int c = 0; c < 1536; c++) begin
      tick();
      if (valid) begin
        cnt++;
        pop_exp(e1);
        chk("stream_left",  32'(sl), 32'(e1.l));
        chk("stream_right", 32'(sr), 32'(e1.r));
      end
    end
    chk("valid_pulses_3_frames", 32'(cnt), 32'd3);
    use_fixed = 1'b0;

    // ---- backpressure across two frames, overrun, clear, transfer ----
    ready = 1'b0;
    do_reset(3);
    wait_valid(700, n, ok);
    chk("bp_latency", 32'(n), 32'd513);
    pop_exp(e0);
    chk("bp_left0",  32'(sl), 32'(e0.l));
    chk("bp_right0", 32'(sr), 32'(e0.r));
    repeat (1020 - 513) tick();
    chk("bp_valid_held", 32'(valid), 32'd1);
    chk("bp_ovr_before", 32'(ovr), 32'd0);
    repeat (10) tick();
    chk("bp_ovr_after", 32'(ovr), 32'd1);
    chk("bp_left_held",  32'(sl), 32'(e0.l));
    chk("bp_right_held", 32'(sr), 32'(e0.r));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ovr_cleared", 32'(ovr), 32'd0);
    chk("bp_left_pre_xfer", 32'(sl), 32'(e0.l));
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("bp_valid_after_xfer", 32'(valid), 32'd0);

    // ---- ready asserted exactly in a commit cycle while valid=1 ----
    do_reset(3);
    wait_valid(700, n, ok);
    pop_exp(e0);
    bc_prev = bclk; lr_prev = lrclk;
    ok = 1'b0;
    for (int c = 0; c < 700 && !ok; c++) begin
      tick();
      if (bc_prev && !bclk && lr_prev && !lrclk) ok = 1'b1;
      bc_prev = bclk;
      lr_prev = lrclk;
    end
    chk("wrap_found", 32'(ok), 32'd1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    pop_exp(e1);
    chk("same_cycle_valid", 32'(valid), 32'd1);
    chk("same_cycle_left",  32'(sl), 32'(e1.l));
    chk("same_cycle_right", 32'(sr), 32'(e1.r));
    chk("same_cycle_ovr",   32'(ovr), 32'd0);
    tick();
    chk("same_cycle_hold_valid", 32'(valid), 32'd1);
    chk("same_cycle_hold_left",  32'(sl), 32'(e1.l));

    // ---- reset mid right slot aborts the frame ----
    ready = 1'b1;
    do_reset(3);
    wait_valid(700, n, ok);
    pop_exp(e0);
    chk("mr_first_left", 32'(sl), 32'(e0.l));
    cnt = 0;
    n = 0;
    while (p != 40 && n < 700) begin
      tick();
      n++;
      if (valid) cnt++;
    end
    chk("mr_reached_b40", 32'(p), 32'd40);
    chk("mr_no_valid_before_rst", 32'(cnt), 32'd0);
    do_reset(3);
    wait_valid(700, n, ok);
    chk("mr_latency", 32'(n), 32'd513);
    pop_exp(e1);
    chk("mr_left",  32'(sl), 32'(e1.l));
    chk("mr_right", 32'(sr), 32'(e1.r));
    chk("mr_ovr", 32'(ovr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
